// File: rtl/radio_power_sequencer.sv
// Power sequencer for the radio timing-engine domain: synchronizes the enable requests, then
// orders power switch, isolation release, settle and the gated enables, and reverses them on shutdown.
module radio_power_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             ck,
  input  logic             arst_n,
  input  logic             radioEnableUnsynced,
  input  logic             radioRxEnUnsynced,
  input  logic [CNT_W-1:0] pwrUpCycles,
  input  logic [CNT_W-1:0] settleCycles,
  output logic             pwrOn,
  output logic             isolateM2,
  output logic             radioEnable,
  output logic             radioRxEn,
  output logic             busy,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PWR_UP = 3'd1,
    ST_DE_ISO = 3'd2,
    ST_SETTLE = 3'd3,
    ST_ON     = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_ISO    = 3'd6,
    ST_PWR_DN = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] en_sync;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   en_s;
  logic                   rx_s;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;

  logic                   pwr_on_d;
  logic                   isolate_d;
  logic                   radio_en_d;
  logic                   rx_en_d;
  logic                   busy_d;

  // NOTE: synchronizer flops get the async reset like every other flop; a chain
  // left unreset could present a stale '1' and start a power-up out of reset.
  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      en_sync <= '0;
      rx_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments so each stage samples the previous stage's old value.
      en_sync <= {en_sync[SYNC_STAGES-2:0], radioEnableUnsynced};
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], radioRxEnUnsynced};
    end
  end

  assign en_s = en_sync[SYNC_STAGES-1];
  assign rx_s = rx_sync[SYNC_STAGES-1];

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (en_s) begin
          state_d = ST_PWR_UP;
          cnt_d   = pwrUpCycles;
        end
      end
      ST_PWR_UP: begin
        // An enable drop outranks dwell expiry on the same cycle.
        if (!en_s)             state_d = ST_PWR_DN;
        else if (cnt_q == '0)  state_d = ST_DE_ISO;
        else                   cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DE_ISO: begin
        if (!en_s) begin
          state_d = ST_ISO;
        end else begin
          state_d = ST_SETTLE;
          cnt_d   = settleCycles;
        end
      end
      ST_SETTLE: begin
        if (!en_s)             state_d = ST_ISO;
        else if (cnt_q == '0)  state_d = ST_ON;
        else                   cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_ON: begin
        if (!en_s) state_d = ST_DRAIN;
      end
      ST_DRAIN:  state_d = ST_ISO;
      ST_ISO:    state_d = ST_PWR_DN;
      ST_PWR_DN: state_d = ST_OFF;
      default:   state_d = ST_OFF;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_comb begin
    pwr_on_d   = !(state_d inside {ST_OFF, ST_PWR_DN});
    isolate_d  = !(state_d inside {ST_DE_ISO, ST_SETTLE, ST_ON, ST_DRAIN});
    radio_en_d = (state_d == ST_ON);
    rx_en_d    = (state_d == ST_ON) && rx_s;
    busy_d     = !(state_d inside {ST_OFF, ST_ON});
  end

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      pwrOn       <= 1'b0;
      isolateM2   <= 1'b1;
      radioEnable <= 1'b0;
      radioRxEn   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pwrOn       <= pwr_on_d;
      isolateM2   <= isolate_d;
      radioEnable <= radio_en_d;
      radioRxEn   <= rx_en_d;
      busy        <= busy_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_radio_power_sequencer.sv
// Directed bench for radio_power_sequencer: reset, nominal and zero-dwell power-up, RX gating,
// shutdown, aborts and mid-sequence reset, with the domain invariants checked after every edge.
module tb_radio_power_sequencer;

  localparam int CNT_W = 8;

  logic             ck;
  logic             arst_n;
  logic             radioEnableUnsynced;
  logic             radioRxEnUnsynced;
  logic [CNT_W-1:0] pwrUpCycles;
  logic [CNT_W-1:0] settleCycles;
  logic             pwrOn;
  logic             isolateM2;
  logic             radioEnable;
  logic             radioRxEn;
  logic             busy;
  logic [2:0]       state;

  int vectors;
  int miscompares;
  logic prev_pwr;
  logic prev_iso;

  radio_power_sequencer #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .ck                  (ck),
    .arst_n              (arst_n),
    .radioEnableUnsynced (radioEnableUnsynced),
    .radioRxEnUnsynced   (radioRxEnUnsynced),
    .pwrUpCycles         (pwrUpCycles),
    .settleCycles        (settleCycles),
    .pwrOn               (pwrOn),
    .isolateM2           (isolateM2),
    .radioEnable         (radioEnable),
    .radioRxEn           (radioRxEn),
    .busy                (busy),
    .state               (state)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 8'(state), 8'd0);
    check({tag, "_pwrOn"}, 8'(pwrOn), 8'd0);
    check({tag, "_isolateM2"}, 8'(isolateM2), 8'd1);
    check({tag, "_radioEnable"}, 8'(radioEnable), 8'd0);
    check({tag, "_radioRxEn"}, 8'(radioRxEn), 8'd0);
    check({tag, "_busy"}, 8'(busy), 8'd0);
  endtask

  // Advance n rising edges, sampling 1 time unit later and checking the invariants each time.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ck);
      #1;
      check("inv_iso_while_unpowered", 8'(!(isolateM2 === 1'b0 && pwrOn === 1'b0)), 8'd1);
      check("inv_en_while_isolated",
            8'(!(isolateM2 === 1'b1 && (radioEnable === 1'b1 || radioRxEn === 1'b1))), 8'd1);
      check("inv_iso_before_pwr_fall",
            8'(!(prev_pwr === 1'b1 && pwrOn === 1'b0 && prev_iso !== 1'b1)), 8'd1);
      prev_pwr = pwrOn;
      prev_iso = isolateM2;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    arst_n              = 1'b0;
    radioEnableUnsynced = 1'b1;
    radioRxEnUnsynced   = 1'b1;
    pwrUpCycles         = 8'd4;
    settleCycles        = 8'd2;

    // Reset values, held across edges while reset is asserted.
    #12;
    check_reset_values("reset");
    @(negedge ck);
    arst_n   = 1'b1;
    prev_pwr = pwrOn;
    prev_iso = isolateM2;

    // Nominal power-up, P=4 S=2, enable and RX request high before edge 1.
    tick(1);  check("nom_e1_state", 8'(state), 8'd0);
    tick(1);  check("nom_e2_state", 8'(state), 8'd0);
    check("nom_e2_pwrOn", 8'(pwrOn), 8'd0);
    tick(1);  check("nom_e3_state", 8'(state), 8'd1);
    check("nom_e3_pwrOn", 8'(pwrOn), 8'd1);
    check("nom_e3_busy", 8'(busy), 8'd1);
    check("nom_e3_iso", 8'(isolateM2), 8'd1);
    tick(4);  check("nom_e7_state", 8'(state), 8'd1);
    check("nom_e7_iso", 8'(isolateM2), 8'd1);
    tick(1);  check("nom_e8_state", 8'(state), 8'd2);
    check("nom_e8_iso", 8'(isolateM2), 8'd0);
    tick(1);  check("nom_e9_state", 8'(state), 8'd3);
    tick(2);  check("nom_e11_state", 8'(state), 8'd3);
    check("nom_e11_busy", 8'(busy), 8'd1);
    check("nom_e11_radioEnable", 8'(radioEnable), 8'd0);
    check("nom_e11_rxEn_gated", 8'(radioRxEn), 8'd0);
    tick(1);  check("nom_e12_state", 8'(state), 8'd4);
    check("nom_e12_radioEnable", 8'(radioEnable), 8'd1);
    check("nom_e12_rxEn", 8'(radioRxEn), 8'd1);
    check("nom_e12_busy", 8'(busy), 8'd0);

    // RX toggling while ON follows three edges later.
    radioRxEnUnsynced = 1'b0;
    tick(2);  check("rx_fall_e2", 8'(radioRxEn), 8'd1);
    tick(1);  check("rx_fall_e3", 8'(radioRxEn), 8'd0);
    radioRxEnUnsynced = 1'b1;
    tick(2);  check("rx_rise_e2", 8'(radioRxEn), 8'd0);
    tick(1);  check("rx_rise_e3", 8'(radioRxEn), 8'd1);

    // Orderly shutdown from ON.
    radioEnableUnsynced = 1'b0;
    tick(2);  check("sd_e2_state", 8'(state), 8'd4);
    check("sd_e2_radioEnable", 8'(radioEnable), 8'd1);
    tick(1);  check("sd_drain_state", 8'(state), 8'd5);
    check("sd_drain_radioEnable", 8'(radioEnable), 8'd0);
    check("sd_drain_rxEn", 8'(radioRxEn), 8'd0);
    check("sd_drain_iso", 8'(isolateM2), 8'd0);
    check("sd_drain_pwrOn", 8'(pwrOn), 8'd1);
    tick(1);  check("sd_iso_state", 8'(state), 8'd6);
    check("sd_iso_iso", 8'(isolateM2), 8'd1);
    check("sd_iso_pwrOn", 8'(pwrOn), 8'd1);
    tick(1);  check("sd_pwrdn_state", 8'(state), 8'd7);
    check("sd_pwrdn_pwrOn", 8'(pwrOn), 8'd0);
    check("sd_pwrdn_busy", 8'(busy), 8'd1);
    tick(1);  check("sd_off_state", 8'(state), 8'd0);
    check("sd_off_busy", 8'(busy), 8'd0);

    // Zero dwell: PWR_UP and SETTLE each one cycle, ON at relative edge 6.
    pwrUpCycles  = 8'd0;
    settleCycles = 8'd0;
    radioEnableUnsynced = 1'b1;
    tick(2);  check("zd_e2_state", 8'(state), 8'd0);
    tick(1);  check("zd_e3_state", 8'(state), 8'd1);
    tick(1);  check("zd_e4_state", 8'(state), 8'd2);
    tick(1);  check("zd_e5_state", 8'(state), 8'd3);
    tick(1);  check("zd_e6_state", 8'(state), 8'd4);
    check("zd_e6_radioEnable", 8'(radioEnable), 8'd1);
    radioEnableUnsynced = 1'b0;
    tick(6);  check("zd_off_state", 8'(state), 8'd0);

    // Abort during PWR_UP: straight to PWR_DN, isolation never released.
    pwrUpCycles = 8'd10;
    radioEnableUnsynced = 1'b1;
    tick(3);  check("apu_e3_state", 8'(state), 8'd1);
    radioEnableUnsynced = 1'b0;
    tick(2);  check("apu_e5_state", 8'(state), 8'd1);
    check("apu_e5_iso", 8'(isolateM2), 8'd1);
    tick(1);  check("apu_e6_state", 8'(state), 8'd7);
    check("apu_e6_pwrOn", 8'(pwrOn), 8'd0);
    check("apu_e6_iso", 8'(isolateM2), 8'd1);
    tick(1);  check("apu_e7_state", 8'(state), 8'd0);
    check("apu_e7_iso", 8'(isolateM2), 8'd1);

    // Abort during SETTLE, then a request during ISO restarts only after OFF.
    pwrUpCycles  = 8'd0;
    settleCycles = 8'd10;
    radioEnableUnsynced = 1'b1;
    tick(5);  check("ast_e5_state", 8'(state), 8'd3);
    check("ast_e5_iso", 8'(isolateM2), 8'd0);
    radioEnableUnsynced = 1'b0;
    tick(2);  check("ast_e7_state", 8'(state), 8'd3);
    tick(1);  check("ast_e8_state", 8'(state), 8'd6);
    check("ast_e8_iso", 8'(isolateM2), 8'd1);
    check("ast_e8_pwrOn", 8'(pwrOn), 8'd1);
    radioEnableUnsynced = 1'b1;
    tick(1);  check("ast_e9_state", 8'(state), 8'd7);
    check("ast_e9_pwrOn", 8'(pwrOn), 8'd0);
    tick(1);  check("ast_e10_state", 8'(state), 8'd0);
    tick(1);  check("ast_e11_restart", 8'(state), 8'd1);
    check("ast_e11_pwrOn", 8'(pwrOn), 8'd1);
    tick(2);  check("ast_e13_state", 8'(state), 8'd3);
    tick(1);  check("ast_e14_state", 8'(state), 8'd3);

    // Asynchronous reset mid-SETTLE takes effect without a clock edge.
    #2;
    arst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    prev_pwr = pwrOn;
    prev_iso = isolateM2;
    tick(1);
    check_reset_values("midrst_held");
    @(negedge ck);
    arst_n = 1'b1;
    tick(2);  check("rel_e2_state", 8'(state), 8'd0);
    tick(1);  check("rel_e3_state", 8'(state), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
